reg_file: RTL



---
 rtl/rv_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 86 ++++++++
 rtl/reg_file.sv | 65 ++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline constants used by decode and the register file.
// Also holds the register-index type and the control-bit positions decode packs into its control word.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 2;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Bit positions inside the decode control word.
  localparam int CTRL_REG_WRITE_BIT = 0;
  localparam int CTRL_MEM_READ_BIT  = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters and the decode hazard/stall equation.
// Counters saturate, and any overflow or underflow sets a sticky error flag.
module reg_scoreboard #(
  parameter int NUM_REGS = rv_pkg::NUM_REGS,
  parameter int CNT_W    = rv_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [rv_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [rv_pkg::REG_ADDR_W-1:0] rs2_addr,
  input  logic                          rs1_used,
  input  logic                          rs2_used,
  input  logic                          resv_en,
  input  logic [rv_pkg::REG_ADDR_W-1:0] resv_addr,
  input  logic                          wr_en,
  input  logic [rv_pkg::REG_ADDR_W-1:0] wr_addr,
  output logic                          stall,
  output logic                          sb_err
);
  import rv_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_reg  [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] ovf;
  logic [NUM_REGS-1:0] unf;
  logic                sb_err_reg;

  // x0 never gets inc/dec, so its counter stays at zero forever.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      if (gi == 0) begin : g_zero
        assign inc[gi] = 1'b0;
        assign dec[gi] = 1'b0;
      end else begin : g_reg
        assign inc[gi] = resv_en && (resv_addr == REG_ADDR_W'(gi));
        assign dec[gi] = wr_en   && (wr_addr   == REG_ADDR_W'(gi));
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_next[i] = cnt_reg[i];
      ovf[i]      = 1'b0;
      unf[i]      = 1'b0;
      if (inc[i] && !dec[i]) begin
        if (cnt_reg[i] == CNT_MAX) ovf[i] = 1'b1;
        else                       cnt_next[i] = cnt_reg[i] + CNT_ONE;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_reg[i] == '0) unf[i] = 1'b1;
        else                  cnt_next[i] = cnt_reg[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= cnt_next[i];
      if ((|ovf) || (|unf)) sb_err_reg <= 1'b1;
    end
  end

  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic             hz1;
  logic             hz2;

  // A last outstanding write landing this cycle is covered by the bypass.
  always_comb begin
    cnt1 = cnt_reg[rs1_addr];
    cnt2 = cnt_reg[rs2_addr];
    hz1  = rs1_used && (cnt1 != '0) && !((cnt1 == CNT_ONE) && wr_en && (wr_addr == rs1_addr));
    hz2  = rs2_used && (cnt2 != '0) && !((cnt2 == CNT_ONE) && wr_en && (wr_addr == rs2_addr));
  end

  assign stall  = hz1 | hz2;
  assign sb_err = sb_err_reg;
endmodule

// File: rtl/reg_file.sv
// Architectural integer register file with write-through bypass for decode reads.
// The pending-write scoreboard that produces stall lives in reg_scoreboard.
module reg_file #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NUM_REGS = rv_pkg::NUM_REGS,
  parameter int CNT_W    = rv_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [rv_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [rv_pkg::REG_ADDR_W-1:0] rs2_addr,
  input  logic                          rs1_used,
  input  logic                          rs2_used,
  output logic [XLEN-1:0]               rs1_data,
  output logic [XLEN-1:0]               rs2_data,
  input  logic                          resv_en,
  input  logic [rv_pkg::REG_ADDR_W-1:0] resv_addr,
  input  logic                          wr_en,
  input  logic [rv_pkg::REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  output logic                          stall,
  output logic                          sb_err
);
  import rv_pkg::*;

  logic [XLEN-1:0] regs_reg [NUM_REGS];
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != ZERO_REG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (wr_live) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = regs_reg[rs1_addr];
    rs2_data = regs_reg[rs2_addr];
    if (wr_live && (wr_addr == rs1_addr)) rs1_data = wr_data;
    if (wr_live && (wr_addr == rs2_addr)) rs2_data = wr_data;
    if (rs1_addr == ZERO_REG) rs1_data = '0;
    if (rs2_addr == ZERO_REG) rs2_data = '0;
  end

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .CNT_W   (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .resv_en  (resv_en),
    .resv_addr(resv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .stall    (stall),
    .sb_err   (sb_err)
  );
endmodule
